// File: rtl/aes_sbox_pkg.sv
// Shared types and sizing for the masked S-box sequencer.
package aes_sbox_pkg;

  localparam int unsigned NBYTES     = 16;
  localparam int unsigned SBOX_LAT   = 2;
  localparam int unsigned RND_W      = 28;
  localparam int unsigned BYTE_IDX_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  function automatic logic [7:0] get_byte(input logic [8*NBYTES-1:0] v,
                                          input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      if (idx == BYTE_IDX_W'(i)) b = v[8*i +: 8];
    return b;
  endfunction

endpackage

// File: rtl/aes_sbox_sched_if.sv
// State, randomness and result handshakes of the S-box sequencer.
interface aes_sbox_sched_if;
  import aes_sbox_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_enc;
  logic [8*NBYTES-1:0]   in_sh0;
  logic [8*NBYTES-1:0]   in_sh1;
  logic                  rnd_valid;
  logic [RND_W-1:0]      rnd_data;
  logic                  rnd_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_sh0;
  logic [8*NBYTES-1:0]   out_sh1;

  modport master (
    output in_valid, in_enc, in_sh0, in_sh1, rnd_valid, rnd_data, out_ready,
    input  in_ready, rnd_ready, out_valid, out_sh0, out_sh1
  );

  modport slave (
    input  in_valid, in_enc, in_sh0, in_sh1, rnd_valid, rnd_data, out_ready,
    output in_ready, rnd_ready, out_valid, out_sh0, out_sh1
  );

endinterface

// File: rtl/aes_sbox_vld_pipe.sv
// Tag shift register that tracks which S-box pipeline slots hold issued bytes.
module aes_sbox_vld_pipe
  import aes_sbox_pkg::*;
#(
  parameter int unsigned DEPTH = SBOX_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  output logic strobe
);

  logic [DEPTH-1:0] tags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags <= '0;
    end else begin
      tags[0] <= push;
      for (int unsigned i = 1; i < DEPTH; i++) tags[i] <= tags[i-1];
    end
  end

  assign strobe = tags[DEPTH-1];

endmodule

// File: rtl/aes_sbox_sched.sv
// Issues a two-share state byte-serially to the masked S-box and reassembles the shared result.
module aes_sbox_sched
  import aes_sbox_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  aes_sbox_sched_if.slave    bus,
  output logic [7:0]         sbox_a,
  output logic [7:0]         sbox_b,
  output logic               sbox_ed,
  output logic [RND_W-1:0]   sbox_random,
  input  logic [7:0]         sbox_s0,
  input  logic [7:0]         sbox_s1,
  output logic               busy
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(NBYTES - 1);

  state_t                 state;
  logic [BYTE_IDX_W-1:0]  issue_cnt;
  logic [BYTE_IDX_W-1:0]  coll_cnt;
  logic [8*NBYTES-1:0]    sh0;
  logic [8*NBYTES-1:0]    sh1;
  logic [8*NBYTES-1:0]    res0;
  logic [8*NBYTES-1:0]    res1;
  logic [RND_W-1:0]       rnd_reg;
  logic                   mode;
  logic                   issue;
  logic                   collect;

  aes_sbox_vld_pipe #(.DEPTH(SBOX_LAT)) u_vld_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (issue),
    .strobe (collect)
  );

  // Shares stay separate end to end: each share byte goes to its own S-box port.
  always_comb begin
    issue       = (state == ISSUE) && bus.rnd_valid;
    sbox_a      = '0;
    sbox_b      = '0;
    sbox_random = rnd_reg;
    if (issue) begin
      sbox_a      = get_byte(sh0, issue_cnt);
      sbox_b      = get_byte(sh1, issue_cnt);
      sbox_random = bus.rnd_data;
    end
    sbox_ed       = mode;
    bus.rnd_ready = issue;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
    bus.out_sh0   = res0;
    bus.out_sh1   = res1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      coll_cnt  <= '0;
      sh0       <= '0;
      sh1       <= '0;
      res0      <= '0;
      res1      <= '0;
      rnd_reg   <= '0;
      mode      <= 1'b1;
    end else begin
      // Results return in issue order, so the collect count alone selects the byte slot.
      if (collect) begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (coll_cnt == BYTE_IDX_W'(i)) begin
            res0[8*i +: 8] <= sbox_s0;
            res1[8*i +: 8] <= sbox_s1;
          end
        end
        coll_cnt <= coll_cnt + BYTE_IDX_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sh0       <= bus.in_sh0;
            sh1       <= bus.in_sh1;
            mode      <= bus.in_enc;
            issue_cnt <= '0;
            coll_cnt  <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            rnd_reg   <= bus.rnd_data;
            issue_cnt <= issue_cnt + BYTE_IDX_W'(1);
            if (issue_cnt == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (collect && coll_cnt == LAST_IDX) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: emulated 2-cycle masked S-box, pass-level model, directed AES vectors.
module tb_aes_sbox_sched;
  import aes_sbox_pkg::*;

  localparam logic [127:0] V_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V_CT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic             clk;
  logic             rst_n;
  logic [7:0]       sbox_a, sbox_b, sbox_s0, sbox_s1;
  logic             sbox_ed, busy;
  logic [RND_W-1:0] sbox_random;

  aes_sbox_sched_if bus();

  aes_sbox_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sbox_a      (sbox_a),
    .sbox_b      (sbox_b),
    .sbox_ed     (sbox_ed),
    .sbox_random (sbox_random),
    .sbox_s0     (sbox_s0),
    .sbox_s1     (sbox_s1),
    .busy        (busy)
  );

  int checks;
  int failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // AES S-box from GF(2^8) inversion plus the affine map.
  logic [7:0] sb_fwd [256];
  logic [7:0] sb_inv [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gf_mul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] r = x;
    for (int k = 1; k <= 4; k++) r ^= (x << k) | (x >> (8 - k));
    return r ^ 8'h63;
  endfunction

  // Emulated masked S-box: two register stages, fresh output mask each cycle, no reset.
  logic [7:0]       st_a, st_b, st_m;
  logic             st_ed;
  logic [RND_W-1:0] st_rnd;

  always @(posedge clk) begin
    st_a    <= sbox_a;
    st_b    <= sbox_b;
    st_ed   <= sbox_ed;
    st_rnd  <= sbox_random;
    st_m    <= 8'($urandom);
    sbox_s0 <= st_m ^ st_rnd[7:0];
    sbox_s1 <= (st_ed ? sb_fwd[st_a ^ st_b] : sb_inv[st_a ^ st_b]) ^ st_m ^ st_rnd[7:0];
  end

  // Pass-level model: accepted state, bytes issued on rnd handshakes, captures SBOX_LAT edges later.
  bit               m_pass, m_done, m_mode;
  int               m_issued, m_coll, ecount;
  logic [127:0]     m_in0, m_in1, m_exp, m_res0, m_res1;
  logic [RND_W-1:0] m_rnd;
  int               due[$];

  initial begin
    m_pass = 0; m_done = 0; m_mode = 1; m_issued = 0; m_coll = 0; ecount = 0;
    m_in0 = '0; m_in1 = '0; m_exp = '0; m_res0 = '0; m_res1 = '0; m_rnd = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pass = 0; m_done = 0; m_mode = 1; m_rnd = '0;
        m_res0 = '0; m_res1 = '0;
        due.delete();
      end else if (m_done) begin
        if (bus.out_ready) m_done = 0;
      end else if (!m_pass) begin
        if (bus.in_valid) begin
          m_pass = 1; m_mode = bus.in_enc; m_issued = 0; m_coll = 0;
          m_in0 = bus.in_sh0; m_in1 = bus.in_sh1;
          due.delete();
          for (int i = 0; i < 16; i++)
            m_exp[8*i +: 8] = m_mode ? sb_fwd[m_in0[8*i +: 8] ^ m_in1[8*i +: 8]]
                                     : sb_inv[m_in0[8*i +: 8] ^ m_in1[8*i +: 8]];
        end
      end else begin
        if (due.size() > 0 && due[0] == ecount) begin
          void'(due.pop_front());
          m_res0[8*m_coll +: 8] = sbox_s0;
          m_res1[8*m_coll +: 8] = sbox_s1;
          m_coll++;
          if (m_coll == 16) begin m_pass = 0; m_done = 1; end
        end
        if (m_issued < 16 && bus.rnd_valid) begin
          m_issued++;
          m_rnd = bus.rnd_data;
          due.push_back(ecount + int'(SBOX_LAT));
        end
      end
      if (clk) ecount++;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    bit         ei;
    logic [7:0] ea, eb;
    forever begin
      @(negedge clk);
      ei = rst_n && m_pass && m_issued < 16 && bus.rnd_valid;
      ea = '0;
      eb = '0;
      if (ei) begin
        ea = m_in0[8*m_issued +: 8];
        eb = m_in1[8*m_issued +: 8];
      end
      chk("in_ready",    128'(bus.in_ready),  128'(!(m_pass || m_done)));
      chk("busy",        128'(busy),          128'(m_pass || m_done));
      chk("out_valid",   128'(bus.out_valid), 128'(m_done));
      chk("rnd_ready",   128'(bus.rnd_ready), 128'(ei));
      chk("sbox_a",      128'(sbox_a),        128'(ea));
      chk("sbox_b",      128'(sbox_b),        128'(eb));
      chk("sbox_random", 128'(sbox_random),   128'(ei ? bus.rnd_data : m_rnd));
      chk("out_sh0",     bus.out_sh0,         m_res0);
      chk("out_sh1",     bus.out_sh1,         m_res1);
      if (m_pass || m_done) chk("sbox_ed", 128'(sbox_ed), 128'(m_mode));
      if (m_done) chk("out_xor", bus.out_sh0 ^ bus.out_sh1, m_exp);
    end
  end

  bit zr;

  task automatic start_pass(input logic [127:0] x, input bit enc, input bit zero);
    logic [127:0] m;
    m  = zero ? '0 : {$urandom, $urandom, $urandom, $urandom};
    zr = zero;
    bus.in_sh0    = m;
    bus.in_sh1    = x ^ m;
    bus.in_enc    = enc;
    bus.in_valid  = 1'b1;
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = zero ? '0 : RND_W'($urandom);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sh0   = {$urandom, $urandom, $urandom, $urandom};
    bus.in_sh1   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input int stall, input int exp_lat, input string name);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 80) begin
      bus.rnd_valid = !(n >= 6 && n < 6 + stall);
      bus.rnd_data  = zr ? '0 : RND_W'($urandom);
      bus.in_valid  = (n >= 3 && n <= 5);
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    chk(name, 128'(n), 128'(exp_lat));
  endtask

  task automatic finish_pass(input int hold);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_in_ready",  128'(bus.in_ready),  128'(0));
      chk("hold_out_valid", 128'(bus.out_valid), 128'(1));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("release_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    checks = 0; failures = 0; zr = 0;
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.in_enc = 1'b0; bus.in_sh0 = '0; bus.in_sh1 = '0;
    bus.rnd_valid = 1'b0; bus.rnd_data = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) sb_fwd[i] = affine(gf_inv(8'(i)));
    for (int i = 0; i < 256; i++) sb_inv[sb_fwd[i]] = 8'(i);
    chk("tab_fwd_00", 128'(sb_fwd[8'h00]), 128'(8'h63));
    chk("tab_fwd_53", 128'(sb_fwd[8'h53]), 128'(8'hed));
    chk("tab_inv_16", 128'(sb_inv[8'h16]), 128'(8'hff));
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy",      128'(busy),          128'(0));
    chk("rst_out_sh0",   bus.out_sh0,         '0);
    chk("rst_sbox_rnd",  128'(sbox_random),   128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS encryption vector, then back-to-back decryption with a 10-cycle hold in DONE
    start_pass(V_PT, 1'b1, 1'b0);
    wait_done(0, 18, "lat_enc");
    chk("res_enc", bus.out_sh0 ^ bus.out_sh1, V_CT);
    finish_pass(0);
    start_pass(V_CT, 1'b0, 1'b0);
    wait_done(0, 18, "lat_dec");
    chk("res_dec", bus.out_sh0 ^ bus.out_sh1, V_PT);
    finish_pass(10);
    chk("res_dec_held", bus.out_sh0 ^ bus.out_sh1, V_PT);

    // Randomness withheld for three cycles after byte 5
    start_pass(V_PT, 1'b1, 1'b0);
    wait_done(3, 21, "lat_stall");
    chk("res_stall", bus.out_sh0 ^ bus.out_sh1, V_CT);
    finish_pass(0);

    // Reset during DRAIN, then a clean pass
    start_pass(V_PT, 1'b1, 1'b0);
    for (int n = 0; n < 17; n++) begin
      bus.rnd_data = RND_W'($urandom);
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_in_ready",  128'(bus.in_ready),  128'(1));
    chk("mrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("mrst_busy",      128'(busy),          128'(0));
    chk("mrst_rnd_ready", 128'(bus.rnd_ready), 128'(0));
    chk("mrst_out_sh0",   bus.out_sh0,         '0);
    chk("mrst_out_sh1",   bus.out_sh1,         '0);
    chk("mrst_sbox_a",    128'(sbox_a),        128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_pass(V_CT, 1'b0, 1'b0);
    wait_done(0, 18, "lat_after_rst");
    chk("res_after_rst", bus.out_sh0 ^ bus.out_sh1, V_PT);
    finish_pass(0);

    // All-zero shares with zero randomness
    start_pass('0, 1'b1, 1'b1);
    wait_done(0, 18, "lat_zero_enc");
    chk("res_zero_enc", bus.out_sh0 ^ bus.out_sh1, {16{8'h63}});
    finish_pass(0);
    start_pass({16{8'h63}}, 1'b0, 1'b1);
    wait_done(0, 18, "lat_zero_dec");
    chk("res_zero_dec", bus.out_sh0 ^ bus.out_sh1, '0);
    finish_pass(0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
